cmpxchg_rmw_seq: RTL and testbench

// - Sequencer wrapped around the combinational CMPXCHG8/16/32 execute datapath.
// - Fetches the r/m destination operand from a register or from locked memory, and presents rm/src/accumulator to the datapath.
// - Captures dest, accumulator and flags, then performs the locked memory write-back and the register write-back.
// - Sits between decode/operand-fetch (upstream) and register/memory write-back (downstream).

---
 rtl/cmpxchg_rmw_seq.sv | 135 +++++++++++++
 tb/tb_cmpxchg_rmw_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmpxchg_rmw_seq.sv
// Locked read-modify-write sequencer around the CMPXCHG execute datapath; done at N+2 (reg) or N+4 (mem, zero-wait).
// Memory handshakes stall the FSM until acked; start is only taken in IDLE and is dropped otherwise.
module cmpxchg_rmw_seq #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  input  logic [1:0]        size,
  input  logic              rm_is_mem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rm_reg_val,
  input  logic [31:0]       src_val,
  input  logic [31:0]       acc_in,
  output logic [31:0]       dp_rm,
  output logic [31:0]       dp_r,
  output logic [31:0]       dp_acc,
  input  logic [31:0]       dp_dest,
  input  logic [31:0]       dp_acc_out,
  input  logic [5:0]        dp_eflags,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_req,
  input  logic              mem_wr_ack,
  output logic [31:0]       mem_wr_data,
  output logic              mem_lock,
  output logic              done,
  output logic [31:0]       dest_out,
  output logic [31:0]       acc_out,
  output logic              rm_we,
  output logic              acc_we,
  output logic [5:0]        flags_out,
  output logic              flags_we
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_REQ = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WR_REQ = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [31:0]       mask_q;
  logic              is_mem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rm_q;
  logic [31:0]       r_q;
  logic [31:0]       acc_op_q;
  logic [31:0]       dest_q;
  logic [31:0]       acc_res_q;
  logic [5:0]        flags_q;
  logic              accept;
  logic [31:0]       start_mask;

  function automatic logic [31:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign accept     = (state_q == S_IDLE) && start;
  assign start_mask = size_mask(size);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = rm_is_mem ? S_RD_REQ : S_EXEC;
      S_RD_REQ: if (mem_rd_ack) state_d = S_EXEC;
      S_EXEC:   state_d = is_mem_q ? S_WR_REQ : S_DONE;
      S_WR_REQ: if (mem_wr_ack) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mask_q    <= 32'd0;
      is_mem_q  <= 1'b0;
      addr_q    <= '0;
      rm_q      <= 32'd0;
      r_q       <= 32'd0;
      acc_op_q  <= 32'd0;
      dest_q    <= 32'd0;
      acc_res_q <= 32'd0;
      flags_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mask_q   <= start_mask;
        is_mem_q <= rm_is_mem;
        addr_q   <= addr;
        rm_q     <= rm_is_mem ? 32'd0 : (rm_reg_val & start_mask);
        r_q      <= src_val & start_mask;
        acc_op_q <= acc_in & start_mask;
      end
      if ((state_q == S_RD_REQ) && mem_rd_ack) begin
        rm_q <= mem_rd_data & mask_q;
      end
      // Results are masked again so a sloppy datapath cannot leak upper bits.
      if (state_q == S_EXEC) begin
        dest_q    <= dp_dest & mask_q;
        acc_res_q <= dp_acc_out & mask_q;
        flags_q   <= dp_eflags;
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign dp_rm       = rm_q;
  assign dp_r        = r_q;
  assign dp_acc      = acc_op_q;
  assign mem_addr    = addr_q;
  assign mem_rd_req  = (state_q == S_RD_REQ);
  assign mem_wr_req  = (state_q == S_WR_REQ);
  assign mem_wr_data = (state_q == S_WR_REQ) ? dest_q : 32'd0;
  // Lock spans read, execute and write so no other master sees the half-updated location.
  assign mem_lock    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ) ||
                       ((state_q == S_EXEC) && is_mem_q);
  assign done        = (state_q == S_DONE);
  assign flags_we    = done;
  assign acc_we      = done && !flags_q[3];
  assign rm_we       = done && !is_mem_q && flags_q[3];
  assign dest_out    = dest_q;
  assign acc_out     = acc_res_q;
  assign flags_out   = flags_q;

endmodule

// File: tb/tb_cmpxchg_rmw_seq.sv
// Directed bench for cmpxchg_rmw_seq with a reference CMPXCHG datapath and an ack responder.
// Self-checking: every comparison goes through chk; summary printed at end.
// Memory responder acks after programmable wait cycles; stray acks injectable.
module tb_cmpxchg_rmw_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic [1:0]  size = 2'b00;
    logic        rm_is_mem = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rm_reg_val = 32'd0;
    logic [31:0] src_val = 32'd0;
    logic [31:0] acc_in = 32'd0;
    logic [31:0] dp_rm, dp_r, dp_acc;
    logic [31:0] dp_dest, dp_acc_out;
    logic [5:0]  dp_eflags;
    logic [31:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_rd_ack;
    logic [31:0] mem_rd_data = 32'd0;
    logic        mem_wr_req;
    logic        mem_wr_ack;
    logic [31:0] mem_wr_data;
    logic        mem_lock;
    logic        done;
    logic [31:0] dest_out, acc_out;
    logic        rm_we, acc_we, flags_we;
    logic [5:0]  flags_out;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_delay = 0, wr_delay = 0, rd_cnt = 0, wr_cnt = 0;
    int n_done = 0, n_rd = 0, n_wr = 0;
    bit stray_rd = 1'b0;
    bit rd_prev = 1'b0, wr_prev = 1'b0;

    int          lat, lock_cyc, snap_done, snap_rd, snap_wr;
    logic [31:0] wr_dat, hi_or, rd_addr_seen;
    bit          timed_out;

    cmpxchg_rmw_seq #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .size(size),
        .rm_is_mem(rm_is_mem), .addr(addr), .rm_reg_val(rm_reg_val), .src_val(src_val),
        .acc_in(acc_in), .dp_rm(dp_rm), .dp_r(dp_r), .dp_acc(dp_acc), .dp_dest(dp_dest),
        .dp_acc_out(dp_acc_out), .dp_eflags(dp_eflags), .mem_addr(mem_addr),
        .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_wr_data(mem_wr_data),
        .mem_lock(mem_lock), .done(done), .dest_out(dest_out), .acc_out(acc_out),
        .rm_we(rm_we), .acc_we(acc_we), .flags_out(flags_out), .flags_we(flags_we)
    );

    always #5 clk = ~clk;

    // Reference CMPXCHG: ZF (bit3) on equality, CF (bit0) on unsigned acc < rm.
    always_comb begin
        dp_eflags    = 6'd0;
        dp_eflags[3] = (dp_acc == dp_rm);
        dp_eflags[0] = (dp_acc < dp_rm);
        dp_dest      = (dp_acc == dp_rm) ? dp_r : dp_rm;
        dp_acc_out   = (dp_acc == dp_rm) ? dp_acc : dp_rm;
    end

    // Memory responder: ack after rd_delay/wr_delay wait cycles, plus event counters.
    always @(negedge clk) begin
        mem_rd_ack = stray_rd;
        mem_wr_ack = 1'b0;
        if (mem_rd_req) begin
            if (rd_cnt >= rd_delay) begin mem_rd_ack = 1'b1; rd_cnt = 0; end
            else rd_cnt++;
        end else rd_cnt = 0;
        if (mem_wr_req) begin
            if (wr_cnt >= wr_delay) begin mem_wr_ack = 1'b1; wr_cnt = 0; end
            else wr_cnt++;
        end else wr_cnt = 0;
        if (done) n_done++;
        if (mem_rd_req && !rd_prev) n_rd++;
        if (mem_wr_req && !wr_prev) n_wr++;
        rd_prev = mem_rd_req;
        wr_prev = mem_wr_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] sz, input logic mem, input logic [31:0] a,
                          input logic [31:0] rmv, input logic [31:0] src, input logic [31:0] acc,
                          input bit poke, output int o_lat, output int o_lock,
                          output logic [31:0] o_wr, output logic [31:0] o_hi,
                          output logic [31:0] o_rda, output bit o_to);
        bit got;
        bit poked;
        size = sz; rm_is_mem = mem; addr = a; rm_reg_val = rmv; src_val = src; acc_in = acc;
        start = 1'b1;
        tick();
        start = 1'b0;
        size = ~sz; rm_is_mem = ~mem; addr = ~a; rm_reg_val = ~rmv; src_val = ~src; acc_in = ~acc;
        o_lat = 1; o_lock = 0; o_wr = 32'd0; o_hi = 32'd0; o_rda = 32'd0; got = 1'b0; poked = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            start = 1'b0;
            o_hi = o_hi | dp_rm | dp_r | dp_acc | mem_wr_data;
            if (done) got = 1'b1;
            else begin
                if (mem_lock) o_lock++;
                if (mem_rd_req) o_rda = mem_addr;
                if (mem_wr_req) begin
                    o_wr = mem_wr_data;
                    if (poke && !poked) begin start = 1'b1; rm_is_mem = 1'b1; poked = 1'b1; end
                end
                tick();
                o_lat++;
            end
        end
        start = 1'b0;
        o_to = !got;
    endtask

    task automatic chk_done(input string t, input logic e_rm_we, input logic e_acc_we,
                            input logic [31:0] e_dest, input logic [31:0] e_acc, input logic [5:0] e_flags);
        chk($sformatf("%s.done", t), done, 1'b1);
        chk($sformatf("%s.flags_we", t), flags_we, 1'b1);
        chk($sformatf("%s.rm_we", t), rm_we, e_rm_we);
        chk($sformatf("%s.acc_we", t), acc_we, e_acc_we);
        chk($sformatf("%s.dest_out", t), dest_out, e_dest);
        chk($sformatf("%s.acc_out", t), acc_out, e_acc);
        chk($sformatf("%s.flags_out", t), flags_out, e_flags);
        chk($sformatf("%s.lock_at_done", t), mem_lock, 1'b0);
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.rd_req", mem_rd_req, 1'b0);
        chk("rst.wr_req", mem_wr_req, 1'b0);
        chk("rst.lock", mem_lock, 1'b0);
        chk("rst.we", {rm_we, acc_we, flags_we}, 3'b000);
        chk("rst.dest_out", dest_out, 32'd0);
        chk("rst.dp_rm", dp_rm, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: register path, 32-bit, equal -> swap in src
        run_op(2'b10, 1'b0, 32'h100, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0,
               lat, lock_cyc, wr_dat, hi_or, rd_addr_seen, timed_out);
        chk("t1.timeout", timed_out, 1'b0);
        chk("t1.latency", lat, 2);
        chk("t1.lock_cycles", lock_cyc, 0);
        chk_done("t1", 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 6'h08);
        tick();
        chk("t1.done_pulse", done, 1'b0);
        chk("t1.dest_held", dest_out, 32'hDEAD_BEEF);

        // 2: memory path, 8-bit, not equal, zero-wait
        mem_rd_data = 32'h9988_7722;
        run_op(2'b00, 1'b1, 32'hA000_0040, 32'h5555_5555, 32'h0000_0033, 32'hAABB_CC11, 1'b0,
               lat, lock_cyc, wr_dat, hi_or, rd_addr_seen, timed_out);
        chk("t2.timeout", timed_out, 1'b0);
        chk("t2.latency", lat, 4);
        chk("t2.lock_cycles", lock_cyc, 3);
        chk("t2.rd_addr", rd_addr_seen, 32'hA000_0040);
        chk("t2.wr_data", wr_dat, 32'h0000_0022);
        chk_done("t2", 1'b0, 1'b1, 32'h0000_0022, 32'h0000_0022, 6'h01);
        tick();

        // 3: memory path, 16-bit, equal, delayed acks
        rd_delay = 3; wr_delay = 2; mem_rd_data = 32'hABCD_1234;
        run_op(2'b01, 1'b1, 32'h0000_2000, 32'h0, 32'h5555_9876, 32'hFFFF_1234, 1'b0,
               lat, lock_cyc, wr_dat, hi_or, rd_addr_seen, timed_out);
        chk("t3.timeout", timed_out, 1'b0);
        chk("t3.latency", lat, 9);
        chk("t3.lock_cycles", lock_cyc, 8);
        chk("t3.wr_data", wr_dat, 32'h0000_9876);
        chk("t3.hi_bits", hi_or[31:16], 16'h0000);
        chk_done("t3", 1'b0, 1'b0, 32'h0000_9876, 32'h0000_1234, 6'h08);
        tick();

        // 4: stray read ack in IDLE, start re-pulsed during WR_REQ
        rd_delay = 0; wr_delay = 1; mem_rd_data = 32'h0000_0007;
        snap_done = n_done; snap_rd = n_rd; snap_wr = n_wr;
        stray_rd = 1'b1;
        tick();
        tick();
        stray_rd = 1'b0;
        chk("t4.stray_busy", busy, 1'b0);
        chk("t4.stray_rd_req", mem_rd_req, 1'b0);
        run_op(2'b10, 1'b1, 32'h0000_3000, 32'h0, 32'h0000_0009, 32'h0000_0005, 1'b1,
               lat, lock_cyc, wr_dat, hi_or, rd_addr_seen, timed_out);
        chk("t4.timeout", timed_out, 1'b0);
        chk("t4.latency", lat, 5);
        chk_done("t4", 1'b0, 1'b1, 32'h0000_0007, 32'h0000_0007, 6'h01);
        for (int i = 0; i < 6; i++) tick();
        chk("t4.done_count", n_done - snap_done, 1);
        chk("t4.rd_count", n_rd - snap_rd, 1);
        chk("t4.wr_count", n_wr - snap_wr, 1);
        chk("t4.idle_after", busy, 1'b0);

        // 5: reset asserted mid RD_REQ
        rd_delay = 20;
        size = 2'b10; rm_is_mem = 1'b1; addr = 32'h0000_4000; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5.rd_req_before", mem_rd_req, 1'b1);
        chk("t5.lock_before", mem_lock, 1'b1);
        tick();
        snap_done = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("t5.rd_req_async", mem_rd_req, 1'b0);
        chk("t5.lock_async", mem_lock, 1'b0);
        chk("t5.busy_async", busy, 1'b0);
        chk("t5.done_async", done, 1'b0);
        chk("t5.dest_cleared", dest_out, 32'd0);
        chk("t5.acc_cleared", acc_out, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5.no_done", n_done - snap_done, 0);
        rd_delay = 0;
        run_op(2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 32'h0000_0040, 32'h0000_0003, 1'b0,
               lat, lock_cyc, wr_dat, hi_or, rd_addr_seen, timed_out);
        chk("t5.timeout", timed_out, 1'b0);
        chk("t5.latency", lat, 2);
        chk_done("t5", 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0080, 6'h01);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
